spi_ctr_ctrl: RTL and testbench
===============================

Name: spi_ctr_ctrl

Overview:
SPI-slave command sequencer that configures and controls the 8-bit tile counter over a 3-wire SPI link.
- Receives fixed 16-bit mode-0 frames (command byte, then data byte) and executes them at frame end: load, enable/direction, read-back.
- Sits between the tile input pins and the counter datapath. SPI signals are oversampled in the `clk` domain.

Parameters:
- WIDTH, 8, counter/data width in bits; frame is fixed at 16 bits, so WIDTH is 8 in all instances.
- SYNC_STAGES, 2, synchronizer flops on spi_sclk, spi_cs_n and spi_mosi (minimum 2).

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock, asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, active low.
- spi_mosi  in  1  SPI data in.
- spi_miso  out  1  SPI data out, registered.
- ctr_value  out  WIDTH  counter value.
- ctr_en  out  1  counting enabled.
- ctr_dir  out  1  0 = count up, 1 = count down.
- busy  out  1  high while a frame is in progress (synced cs_n low).
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Clocking/reset: all state changes on rising `clk`. Reset is synchronous, active-high.
- Reset values: ctr_value=0, ctr_en=0, ctr_dir=0, spi_miso=0, busy=0, frame_err=0, FSM=IDLE.
- Synchronization and edges:
  - spi_sclk, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops.
  - Edges are detected against one further registered copy.
  - Detected-edge latency: SYNC_STAGES+1 clk cycles. spi_sclk frequency must be <= clk/8.
- SPI mode 0, MSB first:
  - MOSI is sampled on the synced sclk rising edge.
  - MISO updates on the synced sclk falling edge. Bit 15 is driven on cs_n falling detection.
- FSM states:
  - WAIT_IDLE: entered after reset; waits for synced cs_n high, then goes to IDLE. A reset mid-frame therefore discards the remainder of that frame.
  - IDLE: cs_n falling -> CMD. Bit counter cleared; MISO loads status bit 7.
  - CMD: 8 rising edges shift the command byte. On the 8th edge: snapshot ctr_value into the TX register, then -> DATA.
  - DATA: 8 rising edges shift the data byte. On the 8th edge -> DONE.
  - DONE: any further rising edge -> ERR. cs_n rising -> execute the command, then -> IDLE.
  - ERR: cs_n rising -> frame_err pulse, no execution, -> IDLE.
  - cs_n rising in CMD or DATA (fewer than 16 bits): frame_err pulse, no execution, -> IDLE.
- Command byte bits [7:6] select the op:
  - 00: NOP/read.
  - 01: write control. ctr_en = data[0], ctr_dir = data[1].
  - 10: load. ctr_value = data.
  - 11: prescale (see Optional Feature).
  - Command bits [5:0] are ignored.
- Execution: takes effect on the clk cycle after cs_n rising is detected. busy drops on the same cycle.
- MISO contents:
  - Byte 0 = status {ctr_en, ctr_dir, 6'b0}.
  - Byte 1 = counter snapshot taken at the 8th rising edge.
  - MISO is held at 0 in IDLE.
- Counter:
  - When ctr_en=1 and a tick is active, ctr_value steps by +1 or -1 modulo 2^WIDTH. 0xFF+1 -> 0x00; 0x00-1 -> 0xFF.
  - Without a prescaler, the tick is active every cycle.
  - A load executed in the same cycle as a tick wins; the tick is dropped.
  - A control write takes effect for the next tick.
- Counting continues unaffected during SPI frames.

Optional Feature:
- Macro: SPI_CTR_PRESCALE_EN.
- Defined:
  - Adds an 8-bit prescale register, reset value 0, and a prescale counter.
  - Op 11 writes prescale = data and clears the prescale counter.
  - The tick is active once every (prescale+1) clk cycles. Prescale 0 gives a tick every cycle.
  - Status byte bit 5 = 1 to advertise the feature.
- Not defined: op 11 is a NOP (no error), ticks occur every cycle, status bit 5 = 0.

Test Plan:
- Reset, then frame 0x80,0x5A -> ctr_value=0x5A one cycle after cs_n rise detection; stays at 0x5A while ctr_en=0; frame_err stays 0.
- Load 0xFE, then frame 0x40,0x01 -> ctr_en=1; values 0xFF, 0x00, 0x01 on successive clks (wrap-around).
- Load 0x01, then frame 0x40,0x03 -> counts down 0x00, 0xFF, 0xFE.
- While counting up, send read frame 0x00,0x00 -> MISO byte0=0x80 (0xA0 with macro); byte1 = ctr_value at the 8th rising sclk; counter keeps running.
- Frame with only 12 sclk edges, and a frame with 17 edges -> each gives a single one-cycle frame_err pulse; ctr_value/ctr_en/ctr_dir unchanged.
- Assert rst mid-frame after 5 bits, keep cs_n low, finish the frame -> frame ignored, outputs at reset values; the next full frame after cs_n returns high executes normally.
- (With macro) frame 0xC0,0x03, then enable -> ctr_value steps once every 4 clks.

Source files
------------

// File: rtl/spi_ctr_ctrl_if.sv
// SPI link bundle between an SPI master and the tile counter sequencer.
interface spi_ctr_ctrl_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_ctr_ctrl.sv
// SPI-slave command sequencer driving the 8-bit tile counter (16-bit mode-0 frames).
// Optional prescaler is built when SPI_CTR_PRESCALE_EN is defined.
module spi_ctr_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  spi_ctr_ctrl_if.slave    spi,
  output logic [WIDTH-1:0] o_ctr_value,
  output logic             o_ctr_en,
  output logic             o_ctr_dir,
  output logic             o_busy,
  output logic             o_frame_err
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_CMD, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   w_sclk, w_cs_n, w_mosi;
  logic                   w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [WIDTH-1:0]       r_rx, r_tx, r_ctr, w_status;
  logic [1:0]             r_op;
  logic                   r_miso, r_en, r_dir, r_busy, r_frame_err;
  logic                   w_start, w_shift, w_snap, w_tx_shift, w_exec, w_err, w_tick;

  // Synchronizers stay unreset so they keep tracking the pins through a reset.
  always_ff @(posedge i_clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
    r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs_n & r_cs_d;
  assign w_cs_rise   = w_cs_n & ~r_cs_d;

`ifdef SPI_CTR_PRESCALE_EN
  localparam logic PSC_FLAG = 1'b1;
  logic [WIDTH-1:0] r_prescale, r_psc_cnt;

  assign w_tick = (r_psc_cnt == r_prescale);

  // Prescale register and tick divider.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prescale <= '0;
      r_psc_cnt  <= '0;
    end else if (w_exec && (r_op == 2'b11)) begin
      r_prescale <= r_rx;
      r_psc_cnt  <= '0;
    end else if (w_tick) begin
      r_psc_cnt  <= '0;
    end else begin
      r_psc_cnt  <= r_psc_cnt + WIDTH'(1);
    end
  end
`else
  localparam logic PSC_FLAG = 1'b0;
  assign w_tick = 1'b1;
`endif

  assign w_status = {r_en, r_dir, PSC_FLAG, {(WIDTH-3){1'b0}}};

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_WAIT_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Frame sequencing; a cs_n rise always closes the frame, even alongside an sclk edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_snap      = 1'b0;
    w_exec      = 1'b0;
    w_err       = 1'b0;
    w_tx_shift  = 1'b0;
    case (r_state)
      S_WAIT_IDLE: begin
        if (w_cs_n) w_state_nxt = S_IDLE;
        else        w_state_nxt = S_WAIT_IDLE;
      end
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_CMD;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CMD, S_DATA: begin
        w_tx_shift = w_sclk_fall;
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(WIDTH-1)) begin
            w_snap      = (r_state == S_CMD);
            w_state_nxt = (r_state == S_CMD) ? S_DATA : S_DONE;
          end else begin
            w_state_nxt = r_state;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DONE: begin
        w_tx_shift = w_sclk_fall;
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_exec      = 1'b1;
        end else if (w_sclk_rise) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_ERR: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  // Shift registers, bit counter and MISO driver.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_op      <= 2'b00;
      r_miso    <= 1'b0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
      r_tx      <= {w_status[WIDTH-2:0], 1'b0};
      r_miso    <= w_status[WIDTH-1];
    end else begin
      if (w_shift) begin
        r_rx      <= {r_rx[WIDTH-2:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      // The command top bits sit in r_rx[6:5] just as its last bit arrives.
      if (w_snap) begin
        r_op <= r_rx[WIDTH-2 -: 2];
        r_tx <= r_ctr;
      end else if (w_tx_shift) begin
        r_tx <= {r_tx[WIDTH-2:0], 1'b0};
      end
      if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT_IDLE)) r_miso <= 1'b0;
      else if (w_tx_shift)                                         r_miso <= r_tx[WIDTH-1];
    end
  end

  // Counter datapath and control register; a load beats a same-cycle tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctr <= '0;
      r_en  <= 1'b0;
      r_dir <= 1'b0;
    end else begin
      if (w_exec && (r_op == 2'b01)) begin
        r_en  <= r_rx[0];
        r_dir <= r_rx[1];
      end
      if (w_exec && (r_op == 2'b10))  r_ctr <= r_rx;
      else if (r_en && w_tick)        r_ctr <= r_dir ? (r_ctr - WIDTH'(1)) : (r_ctr + WIDTH'(1));
    end
  end

  // Frame status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_WAIT_IDLE);
      r_frame_err <= w_err;
    end
  end

  assign spi.spi_miso = r_miso;
  assign o_ctr_value  = r_ctr;
  assign o_ctr_en     = r_en;
  assign o_ctr_dir    = r_dir;
  assign o_busy       = r_busy;
  assign o_frame_err  = r_frame_err;
endmodule

// File: tb/tb_spi_ctr_ctrl.sv
// Bench for spi_ctr_ctrl: frame-level behavioural model checked every cycle plus literal pins.
module tb_spi_ctr_ctrl;
  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;
`ifdef SPI_CTR_PRESCALE_EN
  localparam bit PSC_BIT = 1'b1;
`else
  localparam bit PSC_BIT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] ctr;
  logic         en, dir, busy, ferr;

  spi_ctr_ctrl_if spi_bus ();

  spi_ctr_ctrl #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .spi         (spi_bus),
    .o_ctr_value (ctr),
    .o_ctr_en    (en),
    .o_ctr_dir   (dir),
    .o_busy      (busy),
    .o_frame_err (ferr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  bit chk_on = 1'b0;

  // Model state after posedge number n
  logic [7:0] m_val = 8'h00;
  bit         m_en = 1'b0, m_dir = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  logic [7:0] m_psc = 8'h00;
  int         m_base = 0;
  logic [7:0] hist_val[int];
  bit         hist_en[int], hist_dir[int];
  int         ev_type[int];          // 1 = execute, 2 = frame error
  logic [7:0] ev_cmd[int], ev_data[int];
  bit         bset[int], bclr[int];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] stepped(input logic [7:0] v, input bit e, input bit d, input bit t);
    if (e && t) return d ? v - 8'd1 : v + 8'd1;
    return v;
  endfunction

  // Model: frame results land LAT edges after the cs_n pin rises.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_val = 8'h00; m_en = 1'b0; m_dir = 1'b0; m_busy = 1'b0; m_err = 1'b0;
        m_psc = 8'h00; m_base = cyc;
        ev_type.delete(); ev_cmd.delete(); ev_data.delete(); bset.delete(); bclr.delete();
      end else begin
        automatic bit tick = ((cyc - m_base) % (int'(m_psc) + 1)) == 0;
        m_err = 1'b0;
        if (ev_type.exists(cyc) && ev_type[cyc] == 2) begin
          m_err = 1'b1;
          m_val = stepped(m_val, m_en, m_dir, tick);
        end else if (ev_type.exists(cyc)) begin
          automatic logic [7:0] c = ev_cmd[cyc];
          automatic logic [7:0] d = ev_data[cyc];
          case (c[7:6])
            2'b10: m_val = d;
            2'b01: begin
              m_val = stepped(m_val, m_en, m_dir, tick);
              m_en = d[0]; m_dir = d[1];
            end
            2'b11: begin
              m_val = stepped(m_val, m_en, m_dir, tick);
`ifdef SPI_CTR_PRESCALE_EN
              m_psc = d; m_base = cyc;
`endif
            end
            default: m_val = stepped(m_val, m_en, m_dir, tick);
          endcase
        end else begin
          m_val = stepped(m_val, m_en, m_dir, tick);
        end
        if (bset.exists(cyc)) m_busy = 1'b1;
        if (bclr.exists(cyc)) m_busy = 1'b0;
      end
      hist_val[cyc] = m_val;
      hist_en[cyc]  = m_en;
      hist_dir[cyc] = m_dir;
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (ferr) ferr_cnt++;
      if (chk_on) begin
        check8("ctr_value", ctr, m_val);
        check8("ctr_en", {7'd0, en}, {7'd0, m_en});
        check8("ctr_dir", {7'd0, dir}, {7'd0, m_dir});
        check8("busy", {7'd0, busy}, {7'd0, m_busy});
        check8("frame_err", {7'd0, ferr}, {7'd0, m_err});
        if (!m_busy) check8("miso_idle", {7'd0, spi_bus.spi_miso}, 8'h00);
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_until: at cycle %0d expected cycle %0d", cyc, n);
    end
  endtask

  // Master side of one frame; rst_at >= 0 pulses rst after that bit and drops the frame.
  task automatic spi_frame(input logic [15:0] bits, input int nedges, input int rst_at,
                           output int r_cyc, output logic [15:0] rx, output int f_cyc, output int k8);
    spi_bus.spi_cs_n = 1'b0;
    f_cyc = cyc;
    bset[cyc + LAT] = 1'b1;
    clks(4);
    rx = 16'h0000;
    k8 = -1;
    for (int i = 0; i < nedges; i++) begin
      spi_bus.spi_mosi = (i < 16) ? bits[15-i] : 1'b0;
      clks(4);
      if (i < 16) rx[15-i] = spi_bus.spi_miso;
      spi_bus.spi_sclk = 1'b1;
      if (i == 7) k8 = cyc;
      clks(4);
      spi_bus.spi_sclk = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
      end
    end
    clks(4);
    spi_bus.spi_cs_n = 1'b1;
    r_cyc = cyc;
    if (rst_at < 0) begin
      bclr[cyc + LAT] = 1'b1;
      if (nedges == 16) begin
        ev_type[cyc + LAT] = 1;
        ev_cmd[cyc + LAT]  = bits[15:8];
        ev_data[cyc + LAT] = bits[7:0];
      end else begin
        ev_type[cyc + LAT] = 2;
      end
    end
  endtask

  task automatic send(input logic [15:0] bits, output int r, output logic [15:0] rx);
    int f, k;
    spi_frame(bits, 16, -1, r, rx, f, k);
    check8("miso_status", rx[15:8], {hist_en[f+2], hist_dir[f+2], PSC_BIT, 5'b00000});
    check8("miso_snapshot", rx[7:0], hist_val[k+2]);
  endtask

  int          r, f, k, fe0, v0;
  logic [15:0] rx;

  initial begin
    spi_bus.spi_cs_n = 1'b1;
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_mosi = 1'b0;
    rst = 1'b1;
    clks(4);
    chk_on = 1'b1;
    check8("reset_ctr", ctr, 8'h00);
    check8("reset_en", {7'd0, en}, 8'h00);
    check8("reset_miso", {7'd0, spi_bus.spi_miso}, 8'h00);
    rst = 1'b0;
    clks(4);

    // Load 0x5A; result lands LAT cycles after cs_n rises
    send(16'h805A, r, rx);
    wait_until(r + LAT - 1);
    check8("load_pre", ctr, 8'h00);
    clks(1);
    check8("load_5a", ctr, 8'h5A);
    clks(20);
    check8("hold_5a", ctr, 8'h5A);
    check8("no_ferr", ferr_cnt[7:0], 8'h00);

    // Up-count wrap
    send(16'h80FE, r, rx); clks(8);
    send(16'h4001, r, rx);
    wait_until(r + LAT + 1);
    check8("up_ff", ctr, 8'hFF); clks(1);
    check8("up_00", ctr, 8'h00); clks(1);
    check8("up_01", ctr, 8'h01); clks(5);

    // Down-count wrap
    send(16'h4000, r, rx); clks(8);
    send(16'h8001, r, rx); clks(8);
    send(16'h4003, r, rx);
    wait_until(r + LAT + 1);
    check8("dn_00", ctr, 8'h00); clks(1);
    check8("dn_ff", ctr, 8'hFF); clks(1);
    check8("dn_fe", ctr, 8'hFE); clks(5);

    // Read-back while counting up
    send(16'h4001, r, rx); clks(8);
    send(16'h0000, r, rx);
    check8("read_status", rx[15:8], PSC_BIT ? 8'hA0 : 8'h80);
    clks(8);

    // Short and long frames
    send(16'h4000, r, rx); clks(8);
    send(16'h803C, r, rx); clks(8);
    fe0 = ferr_cnt;
    spi_frame(16'h80AA, 12, -1, r, rx, f, k); clks(8);
    check8("short_err_pulses", 8'(ferr_cnt - fe0), 8'h01);
    check8("short_ctr", ctr, 8'h3C);
    fe0 = ferr_cnt;
    spi_frame(16'h8055, 17, -1, r, rx, f, k); clks(8);
    check8("long_err_pulses", 8'(ferr_cnt - fe0), 8'h01);
    check8("long_ctr", ctr, 8'h3C);
    check8("long_en", {7'd0, en}, 8'h00);

    // Reset mid-frame, then a normal frame
    send(16'h4003, r, rx); clks(8);
    spi_frame(16'h8077, 16, 4, r, rx, f, k); clks(8);
    check8("midrst_ctr", ctr, 8'h00);
    check8("midrst_en", {7'd0, en}, 8'h00);
    send(16'h8011, r, rx); clks(8);
    check8("after_midrst", ctr, 8'h11);

    // Prescale op (NOP when the feature is absent)
    send(16'hC003, r, rx); clks(8);
    send(16'h4001, r, rx); clks(8);
    v0 = ctr;
    clks(16);
    check8("psc_steps", 8'(ctr - v0[7:0]), PSC_BIT ? 8'd4 : 8'd16);
    clks(4);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
